m_trap_controller: RTL and testbench
====================================

Name: m_trap_controller

Overview:
- M-mode trap entry/return sequencer sitting directly downstream of the commit stage and alongside the CSR file.
- Accepts one synchronous exception or mret per handshake and arbitrates pending, enabled interrupts.
- Owns mepc, mcause, mtval, mstatus.{mie,mpie,mpp} and the current privilege level.
- Emits a PC redirect plus pipeline flush for each trap or return.

Parameters:
- XLEN, 64, datapath and CSR width (equals package MXLEN).
- RESET_PC, 64'h0000_0000_8000_0000, reset value of mepc; not used for redirect.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- exc_valid_i  in  1  commit reports an exception.
- exc_ready_o  out  1  block accepts exc/mret this cycle.
- exc_cause_i  in  6  synchronous exception code.
- exc_tval_i  in  XLEN  faulting address or instruction.
- exc_pc_i  in  XLEN  PC of the committing instruction.
- mret_valid_i  in  1  commit reports mret; uses the same exc_ready_o.
- irq_pending_i  in  16  mip bits[15:0].
- irq_enable_i  in  16  mie bits[15:0].
- mtvec_i  in  XLEN  mtvec from the CSR file, decoded as mtvec_t.
- csr_we_i  in  1  software write to an owned CSR.
- csr_addr_i  in  12  CSR address, csr_allocation_t.
- csr_wdata_i  in  XLEN  write data, already merged for set/clear.
- csr_rdata_o  out  XLEN  combinational read of an owned CSR.
- redirect_valid_o  out  1  new PC available.
- redirect_ready_i  in  1  fetch accepts the redirect.
- redirect_pc_o  out  XLEN  target PC.
- flush_o  out  1  one-cycle pulse flushing the pipeline.
- priv_o  out  2  current privilege_level_t.

Behaviour:
- Reset values:
  - state IDLE, priv MACHINE, mstatus.mie=0, mpie=0, mpp=MACHINE.
  - mepc=RESET_PC, mcause=0, mtval=0.
  - exc_ready_o=1, redirect_valid_o=0, flush_o=0, redirect_pc_o=0.
- Interrupt qualification: irq_take = |(irq_pending_i & irq_enable_i) & (mstatus.mie | priv!=MACHINE).
- Interrupt priority, highest first: MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5), LCOF(13).
- IDLE, priority order for same-cycle events:
  1. exc_valid_i: sync exception wins over everything.
  2. mret_valid_i.
  3. irq_take.
  - mret_valid_i and exc_valid_i together: exception taken, mret ignored.
- IDLE -> TRAP on an accepted exception or irq_take. Inputs are captured; exc_ready_o drops the next cycle.
- TRAP (1 cycle):
  - mepc = {pc[XLEN-1:1],1'b0}. For an interrupt, pc is exc_pc_i of the next commit; the bench drives exc_pc_i with the boundary PC.
  - mcause = {interrupt, code zero-extended}. mtval = tval for exceptions, 0 for interrupts.
  - mpie=mie, mie=0, mpp=priv, priv=MACHINE.
  - flush_o=1. Go to REDIRECT.
- IDLE -> RETURN on mret.
- RETURN (1 cycle):
  - mie=mpie, mpie=1, priv=mpp, mpp=USER.
  - flush_o=1. Target = mepc. Go to REDIRECT.
- REDIRECT:
  - redirect_valid_o=1 with a stable pc until redirect_ready_i. Handshake cycle returns to IDLE.
  - New exceptions and interrupts are blocked (exc_ready_o=0).
- Target PC:
  - Exception, or mtvec mode != 1: {mtvec.base,2'b00}.
  - Interrupt with mode 1: {mtvec.base,2'b00} + 4*code. Arithmetic modulo 2^XLEN, wrap permitted.
- CSR writes:
  - Applied only in IDLE and only if no event is accepted the same cycle; the trap wins and the write is dropped.
  - mepc bit0 forced to 0. mcause stores all bits. mstatus writes affect only mie/mpie/mpp; writing mpp=RESERVED stores MACHINE.
- Reset mid-operation: returns to IDLE with reset values next edge. An in-flight redirect is abandoned.

Optional Feature:
- Macro: LAGARTO_VECTORED_MTVEC_EN.
- Defined: vectored interrupt targets as above.
- Undefined: mtvec.mode ignored, all targets are direct base; vectored adder absent.

Decomposition:
- New typedefs in the shared privileged package:
  - trap_state_t (IDLE, TRAP, RETURN, REDIRECT).
  - interrupt priority constant array.
  - trap_request_t {interrupt, code, tval, pc}.
- Reuse existing mstatus_t, mcause_t, mtvec_t, privilege_level_t, csr_allocation_t.
- One sub-module: m_interrupt_arbiter, combinational priority encoder returning valid + 6-bit code.

Test Plan:
- mtvec=0x1000 mode 0, priv U, exc_valid with cause 2, pc 0x2004, tval 0xDEAD -> flush pulse, mepc=0x2004, mcause=2, mtval=0xDEAD, mpp=U, priv=M, redirect 0x1000.
- MACRO defined, mtvec=0x1001, mstatus.mie=1, pending=enable=0x0880 -> MEI chosen, mcause=0x8000_0000_0000_000B, redirect 0x102C, mpie=1, mie=0.
- Same-cycle exc_valid (cause 5) and MTI pending+enabled -> mcause=5; after mret, MTI is taken next.
- mret with mepc=0x3000, mpp=U, mpie=1 -> redirect 0x3000, priv=U, mie=1, mpp=U.
- redirect_ready_i held 0 for 5 cycles -> redirect_valid_o and pc stable, exc_ready_o=0; a new exception waits.
- csr_we to mepc with 0x4001 -> reads 0x4000; csr_we coincident with an exception -> write dropped.

Source files
------------

// File: rtl/m_trap_controller_pkg.sv
// Shared privileged types for the M-mode trap controller.
// CSR layouts, privilege levels, trap FSM states and interrupt priority.
package m_trap_controller_pkg;

  localparam int MXLEN = 64;

  typedef enum logic [1:0] {
    USER       = 2'b00,
    SUPERVISOR = 2'b01,
    RESERVED   = 2'b10,
    MACHINE    = 2'b11
  } privilege_level_t;

  typedef enum logic [11:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MTVEC   = 12'h305,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MTVAL   = 12'h343
  } csr_allocation_t;

  typedef struct packed {
    logic [50:0] rsv_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsv_mid;
    logic        mpie;
    logic [2:0]  rsv_lo2;
    logic        mie;
    logic [2:0]  rsv_lo;
  } mstatus_t;

  typedef struct packed {
    logic             interrupt;
    logic [MXLEN-2:0] code;
  } mcause_t;

  typedef struct packed {
    logic [MXLEN-3:0] base;
    logic [1:0]       mode;
  } mtvec_t;

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    RETURN,
    REDIRECT
  } trap_state_t;

  // Highest priority first: MEI, MSI, MTI, SEI, SSI, STI, LCOF
  localparam int IRQ_NUM = 7;
  localparam logic [5:0] IRQ_PRIO [IRQ_NUM] = '{
    6'd11, 6'd3, 6'd7, 6'd9, 6'd1, 6'd5, 6'd13
  };

  typedef struct packed {
    logic             interrupt;
    logic [5:0]       code;
    logic [MXLEN-1:0] tval;
    logic [MXLEN-1:0] pc;
  } trap_request_t;

endpackage

// File: rtl/m_trap_controller_if.sv
// Commit/fetch/CSR-side bundle of the M-mode trap controller.
// master = pipeline side, slave = trap controller.
interface m_trap_controller_if #(
  parameter int XLEN = 64
);

  logic            exc_valid_i;
  logic            exc_ready_o;
  logic [5:0]      exc_cause_i;
  logic [XLEN-1:0] exc_tval_i;
  logic [XLEN-1:0] exc_pc_i;
  logic            mret_valid_i;
  logic [15:0]     irq_pending_i;
  logic [15:0]     irq_enable_i;
  logic [XLEN-1:0] mtvec_i;
  logic            csr_we_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            redirect_valid_o;
  logic            redirect_ready_i;
  logic [XLEN-1:0] redirect_pc_o;
  logic            flush_o;
  logic [1:0]      priv_o;

  modport master (
    output exc_valid_i, exc_cause_i, exc_tval_i, exc_pc_i,
    output mret_valid_i, irq_pending_i, irq_enable_i, mtvec_i,
    output csr_we_i, csr_addr_i, csr_wdata_i, redirect_ready_i,
    input  exc_ready_o, csr_rdata_o, redirect_valid_o,
    input  redirect_pc_o, flush_o, priv_o
  );

  modport slave (
    input  exc_valid_i, exc_cause_i, exc_tval_i, exc_pc_i,
    input  mret_valid_i, irq_pending_i, irq_enable_i, mtvec_i,
    input  csr_we_i, csr_addr_i, csr_wdata_i, redirect_ready_i,
    output exc_ready_o, csr_rdata_o, redirect_valid_o,
    output redirect_pc_o, flush_o, priv_o
  );

endinterface

// File: rtl/m_interrupt_arbiter.sv
// Fixed-priority encoder over the pending-and-enabled interrupt lines.
// Only standard M/S interrupt sources are considered.
module m_interrupt_arbiter
  import m_trap_controller_pkg::*;
(
  input  logic [15:0] irq_req,
  output logic        irq_valid,
  output logic [5:0]  irq_code
);

  // Walk lowest to highest so the highest-priority hit is left standing.
  always_comb begin
    irq_valid = 1'b0;
    irq_code  = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (irq_req[IRQ_PRIO[i][3:0]]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_PRIO[i];
      end
    end
  end

endmodule

// File: rtl/m_trap_controller.sv
// M-mode trap entry/return sequencer: owns mepc/mcause/mtval/mstatus/priv.
// LAGARTO_VECTORED_MTVEC_EN enables vectored interrupt targets.
module m_trap_controller
  import m_trap_controller_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic                clk_i,
  input logic                rst_i,
  m_trap_controller_if.slave bus
);

  trap_state_t      state;
  privilege_level_t priv;
  privilege_level_t mpp;
  logic             mie;
  logic             mpie;
  logic [XLEN-1:0]  mepc;
  logic [XLEN-1:0]  mcause;
  logic [XLEN-1:0]  mtval;
  trap_request_t    req;

  logic             ready_q;
  logic             rvalid_q;
  logic             flush_q;
  logic [XLEN-1:0]  rpc_q;

  mtvec_t           mtvec;
  mstatus_t         ms_wr;
  mstatus_t         ms_rd;
  logic             irq_valid;
  logic [5:0]       irq_code;
  logic             irq_take;
  logic [XLEN-1:0]  trap_pc;
  privilege_level_t mpp_wr;
  logic             unused_ok;

  assign mtvec = mtvec_t'(bus.mtvec_i);
  assign ms_wr = mstatus_t'(bus.csr_wdata_i);

  m_interrupt_arbiter u_arb (
    .irq_req   (bus.irq_pending_i & bus.irq_enable_i),
    .irq_valid (irq_valid),
    .irq_code  (irq_code)
  );

  assign irq_take = irq_valid & (mie | (priv != MACHINE));

  assign mpp_wr = (ms_wr.mpp == RESERVED) ? MACHINE
                : privilege_level_t'(ms_wr.mpp);

  always_comb begin
    trap_pc = {mtvec.base, 2'b00};
`ifdef LAGARTO_VECTORED_MTVEC_EN
    if (req.interrupt && mtvec.mode == 2'b01) begin
      trap_pc = {mtvec.base, 2'b00}
              + {{(XLEN-8){1'b0}}, req.code, 2'b00};
    end
`endif
  end

  always_comb begin
    ms_rd      = '0;
    ms_rd.mie  = mie;
    ms_rd.mpie = mpie;
    ms_rd.mpp  = mpp;
  end

  always_comb begin
    bus.csr_rdata_o = '0;
    unique case (bus.csr_addr_i)
      CSR_MSTATUS: bus.csr_rdata_o = ms_rd;
      CSR_MEPC:    bus.csr_rdata_o = mepc;
      CSR_MCAUSE:  bus.csr_rdata_o = mcause;
      CSR_MTVAL:   bus.csr_rdata_o = mtval;
      default:     bus.csr_rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      priv     <= MACHINE;
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mpp      <= MACHINE;
      mepc     <= RESET_PC;
      mcause   <= '0;
      mtval    <= '0;
      req      <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      flush_q  <= 1'b0;
      rpc_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.exc_valid_i) begin
            req.interrupt <= 1'b0;
            req.code      <= bus.exc_cause_i;
            req.tval      <= bus.exc_tval_i;
            req.pc        <= bus.exc_pc_i;
            state         <= TRAP;
            ready_q       <= 1'b0;
            flush_q       <= 1'b1;
          end else if (bus.mret_valid_i) begin
            state   <= RETURN;
            ready_q <= 1'b0;
            flush_q <= 1'b1;
          end else if (irq_take) begin
            req.interrupt <= 1'b1;
            req.code      <= irq_code;
            req.tval      <= '0;
            req.pc        <= bus.exc_pc_i;
            state         <= TRAP;
            ready_q       <= 1'b0;
            flush_q       <= 1'b1;
          end else if (bus.csr_we_i) begin
            case (bus.csr_addr_i)
              CSR_MSTATUS: begin
                mie  <= ms_wr.mie;
                mpie <= ms_wr.mpie;
                mpp  <= mpp_wr;
              end
              CSR_MEPC:   mepc   <= {bus.csr_wdata_i[XLEN-1:1], 1'b0};
              CSR_MCAUSE: mcause <= bus.csr_wdata_i;
              CSR_MTVAL:  mtval  <= bus.csr_wdata_i;
              default: ;
            endcase
          end
        end
        TRAP: begin
          mepc     <= {req.pc[XLEN-1:1], 1'b0};
          mcause   <= {req.interrupt, {(XLEN-7){1'b0}}, req.code};
          mtval    <= req.interrupt ? '0 : req.tval;
          mpie     <= mie;
          mie      <= 1'b0;
          mpp      <= priv;
          priv     <= MACHINE;
          flush_q  <= 1'b0;
          rvalid_q <= 1'b1;
          rpc_q    <= trap_pc;
          state    <= REDIRECT;
        end
        RETURN: begin
          mie      <= mpie;
          mpie     <= 1'b1;
          priv     <= mpp;
          mpp      <= USER;
          flush_q  <= 1'b0;
          rvalid_q <= 1'b1;
          rpc_q    <= mepc;
          state    <= REDIRECT;
        end
        REDIRECT: begin
          if (bus.redirect_ready_i) begin
            rvalid_q <= 1'b0;
            ready_q  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.exc_ready_o      = ready_q;
  assign bus.redirect_valid_o = rvalid_q;
  assign bus.redirect_pc_o    = rpc_q;
  assign bus.flush_o          = flush_q;
  assign bus.priv_o           = priv;

  assign unused_ok = ^{mtvec.mode, ms_wr};

endmodule

// File: tb/tb_m_trap_controller.sv
// Scoreboard bench for m_trap_controller: directed traps, returns, stalls.
// Redirects are checked by a monitor against a queue of expected targets.
module tb_m_trap_controller;
  import m_trap_controller_pkg::*;

  localparam int XLEN = 64;

`ifdef LAGARTO_VECTORED_MTVEC_EN
  localparam logic [63:0] MEI_PC = 64'h102C;
  localparam logic [63:0] MTI_PC = 64'h101C;
`else
  localparam logic [63:0] MEI_PC = 64'h1000;
  localparam logic [63:0] MTI_PC = 64'h1000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  m_trap_controller_if #(.XLEN(XLEN)) bus ();

  m_trap_controller #(
    .XLEN     (XLEN),
    .RESET_PC (64'h0000_0000_8000_0000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  priv;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          flush_cnt = 0;
  bit          stalled = 1'b0;
  logic [63:0] stall_pc;

  task automatic check(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stalled   = 1'b0;
      flush_cnt = 0;
    end else begin
      if (bus.flush_o) flush_cnt++;
      if (bus.redirect_valid_o) begin
        if (stalled)
          check("redirect_pc_stable", bus.redirect_pc_o, stall_pc);
        if (bus.redirect_ready_i) begin
          stalled = 1'b0;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_redirect: got pc %h expected none",
                     bus.redirect_pc_o);
          end else begin
            cur = q.pop_front();
            check({cur.name, "_pc"}, bus.redirect_pc_o, cur.pc);
            check({cur.name, "_priv"}, 64'(bus.priv_o), 64'(cur.priv));
            check({cur.name, "_flush"}, 64'(flush_cnt), 64'd1);
          end
          flush_cnt = 0;
        end else begin
          stalled  = 1'b1;
          stall_pc = bus.redirect_pc_o;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string n, logic [63:0] pc, logic [1:0] p);
    exp_t e;
    e.pc   = pc;
    e.priv = p;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic csr_rd(string n, logic [11:0] a, logic [63:0] exp);
    bus.csr_addr_i = a;
    #1;
    check(n, bus.csr_rdata_o, exp);
  endtask

  task automatic csr_wr(logic [11:0] a, logic [63:0] d);
    bus.csr_we_i    = 1'b1;
    bus.csr_addr_i  = a;
    bus.csr_wdata_i = d;
    tick();
    bus.csr_we_i    = 1'b0;
  endtask

  task automatic raise_exc(logic [5:0] c, logic [63:0] pc, logic [63:0] tv);
    bus.exc_valid_i = 1'b1;
    bus.exc_cause_i = c;
    bus.exc_pc_i    = pc;
    bus.exc_tval_i  = tv;
    tick();
    bus.exc_valid_i = 1'b0;
  endtask

  task automatic do_mret();
    bus.mret_valid_i = 1'b1;
    tick();
    bus.mret_valid_i = 1'b0;
  endtask

  task automatic wait_done(string n);
    int k = 0;
    while (!(q.size() == 0 && bus.exc_ready_o && !bus.redirect_valid_o)
           && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", n, q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    bus.exc_valid_i      = 1'b0;
    bus.exc_cause_i      = '0;
    bus.exc_tval_i       = '0;
    bus.exc_pc_i         = '0;
    bus.mret_valid_i     = 1'b0;
    bus.irq_pending_i    = '0;
    bus.irq_enable_i     = '0;
    bus.mtvec_i          = 64'h1000;
    bus.csr_we_i         = 1'b0;
    bus.csr_addr_i       = '0;
    bus.csr_wdata_i      = '0;
    bus.redirect_ready_i = 1'b1;

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_exc_ready", 64'(bus.exc_ready_o), 64'd1);
    check("rst_rvalid", 64'(bus.redirect_valid_o), 64'd0);
    check("rst_flush", 64'(bus.flush_o), 64'd0);
    check("rst_rpc", bus.redirect_pc_o, 64'd0);
    check("rst_priv", 64'(bus.priv_o), 64'd3);
    csr_rd("rst_mstatus", CSR_MSTATUS, 64'h1800);
    csr_rd("rst_mepc", CSR_MEPC, 64'h8000_0000);
    csr_rd("rst_mcause", CSR_MCAUSE, 64'd0);
    csr_rd("rst_mtval", CSR_MTVAL, 64'd0);

    csr_wr(CSR_MSTATUS, 64'h0);
    csr_wr(CSR_MEPC, 64'h2000);
    push("mret_to_u", 64'h2000, 2'd0);
    do_mret();
    wait_done("mret_to_u");
    check("priv_user", 64'(bus.priv_o), 64'd0);

    push("exc_cause2", 64'h1000, 2'd3);
    raise_exc(6'd2, 64'h2004, 64'hDEAD);
    wait_done("exc_cause2");
    csr_rd("exc2_mepc", CSR_MEPC, 64'h2004);
    csr_rd("exc2_mcause", CSR_MCAUSE, 64'd2);
    csr_rd("exc2_mtval", CSR_MTVAL, 64'hDEAD);
    csr_rd("exc2_mstatus", CSR_MSTATUS, 64'h0);
    check("exc2_priv", 64'(bus.priv_o), 64'd3);

    csr_wr(CSR_MSTATUS, 64'h1000);
    csr_rd("mpp_reserved", CSR_MSTATUS, 64'h1800);

    bus.mtvec_i = 64'h1001;
    csr_wr(CSR_MSTATUS, 64'h1808);
    push("irq_mei", MEI_PC, 2'd3);
    bus.irq_pending_i = 16'h0880;
    bus.irq_enable_i  = 16'h0880;
    bus.exc_pc_i      = 64'h5000;
    tick();
    bus.irq_pending_i = '0;
    bus.irq_enable_i  = '0;
    wait_done("irq_mei");
    csr_rd("mei_mcause", CSR_MCAUSE, 64'h8000_0000_0000_000B);
    csr_rd("mei_mepc", CSR_MEPC, 64'h5000);
    csr_rd("mei_mtval", CSR_MTVAL, 64'h0);
    csr_rd("mei_mstatus", CSR_MSTATUS, 64'h1880);

    csr_wr(CSR_MSTATUS, 64'h1808);
    bus.irq_pending_i = 16'h0080;
    bus.irq_enable_i  = 16'h0080;
    push("exc_over_irq", 64'h1000, 2'd3);
    raise_exc(6'd5, 64'h6000, 64'h77);
    wait_done("exc_over_irq");
    csr_rd("exc5_mcause", CSR_MCAUSE, 64'd5);
    csr_rd("exc5_mepc", CSR_MEPC, 64'h6000);
    csr_rd("exc5_mtval", CSR_MTVAL, 64'h77);
    bus.exc_pc_i = 64'h6004;
    push("mret_back", 64'h6000, 2'd3);
    push("irq_mti", MTI_PC, 2'd3);
    do_mret();
    wait_done("irq_mti");
    bus.irq_pending_i = '0;
    bus.irq_enable_i  = '0;
    csr_rd("mti_mcause", CSR_MCAUSE, 64'h8000_0000_0000_0007);
    csr_rd("mti_mepc", CSR_MEPC, 64'h6004);
    csr_rd("mti_mstatus", CSR_MSTATUS, 64'h1880);

    csr_wr(CSR_MEPC, 64'h3000);
    csr_wr(CSR_MSTATUS, 64'h0080);
    push("mret_to_u2", 64'h3000, 2'd0);
    do_mret();
    wait_done("mret_to_u2");
    check("mret2_priv", 64'(bus.priv_o), 64'd0);
    csr_rd("mret2_mstatus", CSR_MSTATUS, 64'h0088);

    bus.mtvec_i          = 64'h1000;
    bus.redirect_ready_i = 1'b0;
    push("stall_exc", 64'h1000, 2'd3);
    push("waiting_exc", 64'h1000, 2'd3);
    raise_exc(6'd3, 64'h7000, 64'h0);
    bus.exc_valid_i = 1'b1;
    bus.exc_cause_i = 6'd4;
    bus.exc_pc_i    = 64'h7100;
    bus.exc_tval_i  = 64'h44;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus.redirect_valid_o), 64'd1);
      check("stall_pc", bus.redirect_pc_o, 64'h1000);
      check("stall_exc_ready", 64'(bus.exc_ready_o), 64'd0);
      tick();
    end
    bus.redirect_ready_i = 1'b1;
    k = 0;
    while (!bus.exc_ready_o && k < 10) begin
      tick();
      k++;
    end
    if (k >= 10) begin
      checks++;
      errors++;
      $display("FAIL stall_release: got exc_ready 0 expected 1");
    end
    tick();
    bus.exc_valid_i = 1'b0;
    wait_done("waiting_exc");
    csr_rd("exc4_mcause", CSR_MCAUSE, 64'd4);
    csr_rd("exc4_mepc", CSR_MEPC, 64'h7100);
    csr_rd("exc4_mtval", CSR_MTVAL, 64'h44);
    csr_rd("exc4_mstatus", CSR_MSTATUS, 64'h1800);

    csr_wr(CSR_MEPC, 64'h4001);
    csr_rd("mepc_bit0", CSR_MEPC, 64'h4000);
    bus.csr_we_i     = 1'b1;
    bus.csr_addr_i   = CSR_MEPC;
    bus.csr_wdata_i  = 64'h9000;
    bus.mret_valid_i = 1'b1;
    push("mret_drop_wr", 64'h4000, 2'd3);
    tick();
    bus.csr_we_i     = 1'b0;
    bus.mret_valid_i = 1'b0;
    wait_done("mret_drop_wr");
    csr_rd("drop_mepc", CSR_MEPC, 64'h4000);

    bus.csr_we_i    = 1'b1;
    bus.csr_addr_i  = CSR_MSTATUS;
    bus.csr_wdata_i = 64'h1808;
    push("exc_drop_wr", 64'h1000, 2'd3);
    raise_exc(6'd6, 64'h8000, 64'h66);
    bus.csr_we_i = 1'b0;
    wait_done("exc_drop_wr");
    csr_rd("drop_mstatus", CSR_MSTATUS, 64'h1800);
    csr_rd("drop_mcause", CSR_MCAUSE, 64'd6);
    csr_rd("drop_exc_mepc", CSR_MEPC, 64'h8000);

    bus.redirect_ready_i = 1'b0;
    raise_exc(6'd1, 64'hA000, 64'h0);
    tick();
    check("pre_reset_valid", 64'(bus.redirect_valid_o), 64'd1);
    rst = 1'b1;
    q.delete();
    tick();
    check("mid_rst_rvalid", 64'(bus.redirect_valid_o), 64'd0);
    check("mid_rst_exc_ready", 64'(bus.exc_ready_o), 64'd1);
    check("mid_rst_flush", 64'(bus.flush_o), 64'd0);
    check("mid_rst_rpc", bus.redirect_pc_o, 64'd0);
    check("mid_rst_priv", 64'(bus.priv_o), 64'd3);
    csr_rd("mid_rst_mepc", CSR_MEPC, 64'h8000_0000);
    csr_rd("mid_rst_mcause", CSR_MCAUSE, 64'd0);
    rst = 1'b0;
    bus.redirect_ready_i = 1'b1;
    repeat (3) tick();
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
